// File: rtl/bram_read_router2.sv
// Two-requester read front end for one shared single-port BRAM.
// It arbitrates addresses onto the memory port and uses a tag pipeline to send
// each piece of returned data back to the requester that issued the read.
// Optional macro BRAM_ROUTER_FIXED_PRIO_EN: requester 1 always wins contention.
module bram_read_router2 #(
   parameter int ADDR_W       = 14,
   parameter int DATA_W       = 16,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              req1_valid_i,
   input  logic [ADDR_W-1:0] req1_addr_i,
   output logic              req1_ready_o,
   input  logic              req2_valid_i,
   input  logic [ADDR_W-1:0] req2_addr_i,
   output logic              req2_ready_o,
   output logic              mem_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              rsp1_valid_o,
   output logic [DATA_W-1:0] rsp1_data_o,
   output logic              rsp2_valid_o,
   output logic [DATA_W-1:0] rsp2_data_o
);

   localparam int TAG_DEPTH = READ_LATENCY + 1;

   logic                 grant1, grant2, accept;
   logic                 memEn_q, memEn_d;
   logic [ADDR_W-1:0]    memAddr_q, memAddr_d;
   logic [TAG_DEPTH-1:0] tagValid_q, tagValid_d;
   logic [TAG_DEPTH-1:0] tagPort2_q, tagPort2_d;
   logic                 rsp1Valid_q, rsp1Valid_d;
   logic                 rsp2Valid_q, rsp2Valid_d;
   logic [DATA_W-1:0]    rsp1Data_q, rsp1Data_d;
   logic [DATA_W-1:0]    rsp2Data_q, rsp2Data_d;

`ifdef BRAM_ROUTER_FIXED_PRIO_EN
   always_comb begin
      grant1 = req1_valid_i;
      grant2 = req2_valid_i & ~req1_valid_i;
   end
`else
   // Set when requester 2 received the most recent grant; reset favours requester 1 next.
   logic lastGrant2_q, lastGrant2_d;

   always_comb begin
      grant1 = req1_valid_i & (~req2_valid_i | lastGrant2_q);
      grant2 = req2_valid_i & (~req1_valid_i | ~lastGrant2_q);
      lastGrant2_d = lastGrant2_q;
      if (grant2) begin
         lastGrant2_d = 1'b1;
      end else if (grant1) begin
         lastGrant2_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         lastGrant2_q <= 1'b1;
      end else begin
         lastGrant2_q <= lastGrant2_d;
      end
   end
`endif

   assign accept       = grant1 | grant2;
   assign req1_ready_o = grant1;
   assign req2_ready_o = grant2;

   // Tag slot READ_LATENCY lines up with the data currently on mem_rdata_i.
   always_comb begin
      memEn_d   = accept;
      memAddr_d = memAddr_q;
      if (grant2) begin
         memAddr_d = req2_addr_i;
      end else if (grant1) begin
         memAddr_d = req1_addr_i;
      end
      tagValid_d  = {tagValid_q[TAG_DEPTH-2:0], accept};
      tagPort2_d  = {tagPort2_q[TAG_DEPTH-2:0], grant2};
      rsp1Valid_d = tagValid_q[READ_LATENCY] & ~tagPort2_q[READ_LATENCY];
      rsp2Valid_d = tagValid_q[READ_LATENCY] &  tagPort2_q[READ_LATENCY];
      rsp1Data_d  = rsp1Valid_d ? mem_rdata_i : rsp1Data_q;
      rsp2Data_d  = rsp2Valid_d ? mem_rdata_i : rsp2Data_q;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         memEn_q     <= 1'b0;
         memAddr_q   <= '0;
         tagValid_q  <= '0;
         tagPort2_q  <= '0;
         rsp1Valid_q <= 1'b0;
         rsp2Valid_q <= 1'b0;
         rsp1Data_q  <= '0;
         rsp2Data_q  <= '0;
      end else begin
         memEn_q     <= memEn_d;
         memAddr_q   <= memAddr_d;
         tagValid_q  <= tagValid_d;
         tagPort2_q  <= tagPort2_d;
         rsp1Valid_q <= rsp1Valid_d;
         rsp2Valid_q <= rsp2Valid_d;
         rsp1Data_q  <= rsp1Data_d;
         rsp2Data_q  <= rsp2Data_d;
      end
   end

   assign mem_en_o     = memEn_q;
   assign mem_addr_o   = memAddr_q;
   assign rsp1_valid_o = rsp1Valid_q;
   assign rsp1_data_o  = rsp1Data_q;
   assign rsp2_valid_o = rsp2Valid_q;
   assign rsp2_data_o  = rsp2Data_q;

endmodule

// File: tb/tb_bram_read_router2.sv
// Directed bench for bram_read_router2: one instance at read latency 1 and one at 3,
// each fed by a memory model that returns address + 0x100.
module tb_bram_read_router2;

   logic        clk = 1'b0;
   logic        reset;
   logic        r1v, r2v, r1rdy, r2rdy, memEn, rsp1v, rsp2v;
   logic [13:0] r1a, r2a, memAddr;
   logic [15:0] memRdata, rsp1d, rsp2d;

   logic        d3r1v, d3r2v, d3r1rdy, d3r2rdy, d3memEn, d3rsp1v, d3rsp2v;
   logic [13:0] d3r1a, d3r2a, d3memAddr;
   logic [15:0] d3memRdata, d3rsp1d, d3rsp2d;
   logic [15:0] s1, s2, s3;

   int total = 0;
   int bad   = 0;

   int expG1   [4];
   int expEn   [8];
   int expAddr [8];
   int expR1v  [8];
   int expR2v  [8];
   int expD    [8];

   always #5 clk = ~clk;

   bram_read_router2 #(.ADDR_W(14), .DATA_W(16), .READ_LATENCY(1)) dut (
      .clk_i(clk), .reset_i(reset),
      .req1_valid_i(r1v), .req1_addr_i(r1a), .req1_ready_o(r1rdy),
      .req2_valid_i(r2v), .req2_addr_i(r2a), .req2_ready_o(r2rdy),
      .mem_en_o(memEn), .mem_addr_o(memAddr), .mem_rdata_i(memRdata),
      .rsp1_valid_o(rsp1v), .rsp1_data_o(rsp1d),
      .rsp2_valid_o(rsp2v), .rsp2_data_o(rsp2d)
   );

   bram_read_router2 #(.ADDR_W(14), .DATA_W(16), .READ_LATENCY(3)) dut3 (
      .clk_i(clk), .reset_i(reset),
      .req1_valid_i(d3r1v), .req1_addr_i(d3r1a), .req1_ready_o(d3r1rdy),
      .req2_valid_i(d3r2v), .req2_addr_i(d3r2a), .req2_ready_o(d3r2rdy),
      .mem_en_o(d3memEn), .mem_addr_o(d3memAddr), .mem_rdata_i(d3memRdata),
      .rsp1_valid_o(d3rsp1v), .rsp1_data_o(d3rsp1d),
      .rsp2_valid_o(d3rsp2v), .rsp2_data_o(d3rsp2d)
   );

   // Memory models: data = address + 0x100, after 1 and 3 cycles respectively.
   always @(posedge clk) begin
      if (memEn) memRdata <= {2'b00, memAddr} + 16'h0100;
      s1 <= d3memEn ? ({2'b00, d3memAddr} + 16'h0100) : 16'h0000;
      s2 <= s1;
      s3 <= s2;
   end
   assign d3memRdata = s3;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v1, input logic [13:0] a1,
                                input logic v2, input logic [13:0] a2);
      r1v = v1; r1a = a1; r2v = v2; r2a = a2;
   endtask

   task automatic checkOutput(input string tagName, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tagName, observed, expected);
      end
   endtask

   initial begin
      int a1, a2;
      reset = 1'b1;
      applyStimulus(1'b0, 14'h0, 1'b0, 14'h0);
      d3r1v = 1'b0; d3r1a = 14'h0; d3r2v = 1'b0; d3r2a = 14'h0;
      memRdata = 16'h0;
      tick();
      tick();

      // Reset state
      checkOutput("rstMemEn", memEn, 0);
      checkOutput("rstMemAddr", memAddr, 0);
      checkOutput("rstRsp1v", rsp1v, 0);
      checkOutput("rstRsp2v", rsp2v, 0);
      checkOutput("rstRsp1d", rsp1d, 0);
      checkOutput("rstRsp2d", rsp2d, 0);
      checkOutput("rstD3Rsp1v", d3rsp1v, 0);
      reset = 1'b0;

      // Single read from requester 1
      applyStimulus(1'b1, 14'h0012, 1'b0, 14'h0);
      #1;
      checkOutput("singleRdy1", r1rdy, 1);
      checkOutput("singleRdy2", r2rdy, 0);
      tick();
      applyStimulus(1'b0, 14'h0, 1'b0, 14'h0);
      checkOutput("singleMemEn", memEn, 1);
      checkOutput("singleMemAddr", memAddr, 32'h12);
      checkOutput("singleRsp1vC1", rsp1v, 0);
      tick();
      checkOutput("singleMemEnOff", memEn, 0);
      checkOutput("singleMemAddrHold", memAddr, 32'h12);
      checkOutput("singleRsp1vC2", rsp1v, 0);
      tick();
      checkOutput("singleRsp1v", rsp1v, 1);
      checkOutput("singleRsp1d", rsp1d, 32'h0112);
      checkOutput("singleRsp2v", rsp2v, 0);
      tick();
      checkOutput("singleRsp1vEnd", rsp1v, 0);
      checkOutput("singleRsp1dHold", rsp1d, 32'h0112);

      // Contention from reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
`ifdef BRAM_ROUTER_FIXED_PRIO_EN
      expG1   = '{1, 1, 1, 1};
      expEn   = '{0, 1, 1, 1, 1, 0, 0, 0};
      expAddr = '{0, 'h100, 'h101, 'h102, 'h103, 0, 0, 0};
      expR1v  = '{0, 0, 0, 1, 1, 1, 1, 0};
      expR2v  = '{0, 0, 0, 0, 0, 0, 0, 0};
      expD    = '{0, 0, 0, 'h200, 'h201, 'h202, 'h203, 0};
`else
      expG1   = '{1, 0, 1, 0};
      expEn   = '{0, 1, 1, 1, 1, 0, 0, 0};
      expAddr = '{0, 'h100, 'h200, 'h101, 'h201, 0, 0, 0};
      expR1v  = '{0, 0, 0, 1, 0, 1, 0, 0};
      expR2v  = '{0, 0, 0, 0, 1, 0, 1, 0};
      expD    = '{0, 0, 0, 'h200, 'h300, 'h201, 'h301, 0};
`endif
      a1 = 'h100;
      a2 = 'h200;
      for (int c = 0; c < 8; c++) begin
         checkOutput($sformatf("contMemEn%0d", c), memEn, expEn[c]);
         if (expEn[c] != 0) checkOutput($sformatf("contMemAddr%0d", c), memAddr, expAddr[c]);
         checkOutput($sformatf("contRsp1v%0d", c), rsp1v, expR1v[c]);
         checkOutput($sformatf("contRsp2v%0d", c), rsp2v, expR2v[c]);
         checkOutput($sformatf("contOneHot%0d", c), rsp1v & rsp2v, 0);
         if (expR1v[c] != 0) checkOutput($sformatf("contRsp1d%0d", c), rsp1d, expD[c]);
         if (expR2v[c] != 0) checkOutput($sformatf("contRsp2d%0d", c), rsp2d, expD[c]);
         if (c < 4) applyStimulus(1'b1, a1[13:0], 1'b1, a2[13:0]);
         else       applyStimulus(1'b0, 14'h0, 1'b0, 14'h0);
         #1;
         if (c < 4) begin
            checkOutput($sformatf("contRdy1_%0d", c), r1rdy, expG1[c]);
            checkOutput($sformatf("contRdy2_%0d", c), r2rdy, 1 - expG1[c]);
         end
         tick();
         if (c < 4) begin
            if (expG1[c] != 0) a1++;
            else               a2++;
         end
      end

      // Back-to-back reads on requester 2 up to the top address
      for (int c = 0; c < 8; c++) begin
         checkOutput($sformatf("b2bMemEn%0d", c), memEn, (c >= 1 && c <= 4) ? 1 : 0);
         if (c >= 1 && c <= 4) checkOutput($sformatf("b2bMemAddr%0d", c), memAddr, 'h3FFC + c - 1);
         checkOutput($sformatf("b2bRsp2v%0d", c), rsp2v, (c >= 3 && c <= 6) ? 1 : 0);
         if (c >= 3 && c <= 6) checkOutput($sformatf("b2bRsp2d%0d", c), rsp2d, 'h40FC + c - 3);
         checkOutput($sformatf("b2bRsp1v%0d", c), rsp1v, 0);
         if (c < 4) begin
            applyStimulus(1'b0, 14'h0, 1'b1, 14'h3FFC + 14'(c));
            #1;
            checkOutput($sformatf("b2bRdy2_%0d", c), r2rdy, 1);
            checkOutput($sformatf("b2bRdy1_%0d", c), r1rdy, 0);
         end else begin
            applyStimulus(1'b0, 14'h0, 1'b0, 14'h0);
         end
         tick();
      end

      // Reset while two reads are in flight
      applyStimulus(1'b1, 14'h0010, 1'b0, 14'h0);
      tick();
      applyStimulus(1'b1, 14'h0011, 1'b0, 14'h0);
      tick();
      applyStimulus(1'b0, 14'h0, 1'b0, 14'h0);
      checkOutput("midMemEn2", memEn, 1);
      checkOutput("midMemAddr2", memAddr, 32'h11);
      tick();
      reset = 1'b1;
      checkOutput("midRsp1vPre", rsp1v, 1);
      checkOutput("midRsp1dPre", rsp1d, 32'h0110);
      tick();
      reset = 1'b0;
      checkOutput("midMemEnRst", memEn, 0);
      checkOutput("midMemAddrRst", memAddr, 0);
      checkOutput("midRsp1vRst", rsp1v, 0);
      checkOutput("midRsp2vRst", rsp2v, 0);
      checkOutput("midRsp1dRst", rsp1d, 0);
      checkOutput("midRsp2dRst", rsp2d, 0);
      for (int c = 0; c < 4; c++) begin
         tick();
         checkOutput($sformatf("midRsp1vPost%0d", c), rsp1v, 0);
         checkOutput($sformatf("midRsp2vPost%0d", c), rsp2v, 0);
      end

      // Read latency 3: response five cycles after acceptance
      d3r1v = 1'b1;
      d3r1a = 14'h0ABC;
      #1;
      checkOutput("lat3Rdy1", d3r1rdy, 1);
      tick();
      d3r1v = 1'b0;
      for (int c = 1; c < 7; c++) begin
         checkOutput($sformatf("lat3Rsp1v%0d", c), d3rsp1v, (c == 5) ? 1 : 0);
         if (c == 5) checkOutput("lat3Rsp1d", d3rsp1d, 32'h0BBC);
         checkOutput($sformatf("lat3Rsp2v%0d", c), d3rsp2v, 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
